// File: rtl/alu_pkg.sv
// Shared encodings for the bitwise/shift sequencer: op codes, FSM states, default width.
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Narrow shift stage: moves acc by d in [0, STEP] positions, zero fill, direction from left.
module shift_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned STEP  = 1,
    parameter int unsigned DW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [DW-1:0]    d,
    input  logic             left,
    output logic [WIDTH-1:0] res_c
);

    // One mux leg per legal distance; d == 0 passes acc through.
    always_comb begin
        res_c = acc;
        for (int unsigned i = 1; i <= STEP; i++) begin
            if (d == DW'(i)) begin
                res_c = left ? (acc << i) : (acc >> i);
            end
        end
    end

endmodule

// File: rtl/shift_logic_seq.sv
// Multi-cycle AND/OR/SLL/SRL sequencer with valid/ready on both sides.
// Shifts iterate at most STEP bit positions per cycle through shift_step.
module shift_logic_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned STEP  = 1,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int unsigned DW = $clog2(STEP + 1);

    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
            $error("shift_logic_seq: STEP must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_e           state_q, state_d;
    logic             left_q, left_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [DW-1:0]    step_amt_c;
    logic [SHW-1:0]   rem_next_c;
    logic [WIDTH-1:0] step_res_c;

    // Distance this cycle: min(STEP, remaining), so remaining never underflows.
    always_comb begin
        step_amt_c = (32'(rem_q) > STEP) ? DW'(STEP) : DW'(rem_q);
        rem_next_c = rem_q - SHW'(step_amt_c);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .DW    (DW)
    ) u_shift_step (
        .acc   (acc_q),
        .d     (step_amt_c),
        .left  (left_q),
        .res_c (step_res_c)
    );

    always_comb begin
        state_d  = state_q;
        left_d   = left_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;

        // flush wins over a same-cycle accept or retire.
        if (flush) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        case (in_op)
                            OP_AND: begin
                                result_d = in_a & in_b;
                                state_d  = DONE;
                            end
                            OP_OR: begin
                                result_d = in_a | in_b;
                                state_d  = DONE;
                            end
                            OP_SLL, OP_SRL: begin
                                if (in_shamt == '0) begin
                                    result_d = in_b;
                                    state_d  = DONE;
                                end else begin
                                    acc_d   = in_b;
                                    rem_d   = in_shamt;
                                    left_d  = (in_op == OP_SLL);
                                    state_d = SHIFT;
                                end
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    acc_d = step_res_c;
                    rem_d = rem_next_c;
                    if (rem_next_c == '0) begin
                        result_d = step_res_c;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            left_q      <= 1'b0;
            acc_q       <= '0;
            rem_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_shift_logic_seq.sv
// Directed bench for shift_logic_seq: STEP=1 and STEP=4 instances, scoreboard queue of results.
module tb_shift_logic_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid4;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_shamt;
    logic        flush;
    logic        out_ready;

    logic        in_ready1, out_valid1, busy1;
    logic [31:0] out_result1;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] out_result4;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          lat;
    logic        seen;
    logic [1:0]  r_op;
    logic [4:0]  r_sh;

    always #5 clk = ~clk;

    shift_logic_seq #(.WIDTH(32), .STEP(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready1),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_shamt   (in_shamt),
        .flush      (flush),
        .out_valid  (out_valid1),
        .out_ready  (out_ready),
        .out_result (out_result1),
        .busy       (busy1)
    );

    shift_logic_seq #(.WIDTH(32), .STEP(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_shamt   (in_shamt),
        .flush      (flush),
        .out_valid  (out_valid4),
        .out_ready  (out_ready),
        .out_result (out_result4),
        .busy       (busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return b << sh;
            default: return b >> sh;
        endcase
    endfunction

    // Edges from the accept edge until out_valid is seen.
    function automatic int exp_lat(input logic [1:0] op, input logic [4:0] sh, input int step);
        if (!op[1] || sh == 5'd0) return 1;
        return 1 + (int'(sh) + step - 1) / step;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
        int          n;
        logic [31:0] e;
        out_ready = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_shamt  = sh;
        in_valid  = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready1), 32'd1);
        exp_q.push_back(model(op, a, b, sh));
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat(op, sh, 1)));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_result"}, out_result1, e);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_shamt  = '0;

        #12;
        check("rst_in_ready", 32'(in_ready1), 32'd1);
        check("rst_out_valid", 32'(out_valid1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_result", out_result1, 32'd0);
        #1 rst = 1'b0;
        tick();

        run_op("and", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
        run_op("or", OP_OR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
        run_op("srl_sh0", OP_SRL, 32'h0, 32'hDEADBEEF, 5'd0);
        run_op("srl_31", OP_SRL, 32'h0, 32'h80000000, 5'd31);
        run_op("sll_1", OP_SLL, 32'h0, 32'h0000_00F1, 5'd1);

        for (int i = 0; i < 6; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_sh = 5'($urandom_range(0, 31));
            run_op("rand", r_op, $urandom, $urandom, r_sh);
        end

        // STEP=4 instance: 31-bit left shift takes 8 shift cycles.
        out_ready = 1'b1;
        in_op     = OP_SLL;
        in_b      = 32'h00000001;
        in_shamt  = 5'd31;
        in_valid4 = 1'b1;
        exp_q.push_back(model(OP_SLL, 32'h0, 32'h00000001, 5'd31));
        tick();
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 100) begin
            tick();
            lat++;
        end
        check("step4_latency", 32'(lat), 32'(exp_lat(OP_SLL, 5'd31, 4)));
        check("step4_result", out_result4, exp_q.pop_front());
        tick();

        // Backpressure: result held while a second request waits.
        out_ready = 1'b0;
        in_op     = OP_AND;
        in_a      = 32'h1234_5678;
        in_b      = 32'h0F0F_F0F0;
        in_valid  = 1'b1;
        exp_q.push_back(model(OP_AND, 32'h1234_5678, 32'h0F0F_F0F0, 5'd0));
        tick();
        in_op = OP_OR;
        in_a  = 32'hA000_0005;
        in_b  = 32'h0000_0F00;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid1), 32'd1);
            check("bp_result", out_result1, exp_q[0]);
            check("bp_in_ready", 32'(in_ready1), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(model(OP_OR, 32'hA000_0005, 32'h0000_0F00, 5'd0));
        tick();
        check("bp_retired_valid", 32'(out_valid1), 32'd0);
        check("bp_retired_ready", 32'(in_ready1), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_second_valid", 32'(out_valid1), 32'd1);
        check("bp_second_result", out_result1, exp_q.pop_front());
        tick();

        // flush on the third shift cycle drops the operation.
        in_op    = OP_SLL;
        in_b     = 32'h0000_0001;
        in_shamt = 5'd20;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("fl_busy", 32'(busy1), 32'd1);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_in_ready", 32'(in_ready1), 32'd1);
        check("fl_busy_after", 32'(busy1), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            seen = seen | out_valid1;
            tick();
        end
        check("fl_never_valid", 32'(seen), 32'd0);

        // flush alongside a request in IDLE: request refused.
        in_op    = OP_AND;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("fl_idle_busy", 32'(busy1), 32'd0);
        check("fl_idle_ready", 32'(in_ready1), 32'd1);
        tick();
        check("fl_idle_valid", 32'(out_valid1), 32'd0);

        // Asynchronous reset between edges mid-shift.
        in_op    = OP_SRL;
        in_b     = 32'h8000_0000;
        in_shamt = 5'd31;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("arst_busy_before", 32'(busy1), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready1), 32'd1);
        check("arst_out_valid", 32'(out_valid1), 32'd0);
        check("arst_busy", 32'(busy1), 32'd0);
        check("arst_result", out_result1, 32'd0);
        #1 rst = 1'b0;
        tick();
        run_op("and_after_rst", OP_AND, 32'hCAFE_F00D, 32'h0FF0_FF00, 5'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
